// File: rtl/relu_pool_pkg.sv
// relu_pool_pkg: shared widths, default geometry and data typedefs for the relu/pool block
package relu_pool_pkg;
  localparam int Y_W = 23;
  localparam int ZW_DEF = 16;
  localparam int L_DEF = 8;
  localparam int P_DEF = 2;
  typedef logic signed [Y_W-1:0] y_t;
  typedef logic [ZW_DEF-1:0] z_t;
endpackage

// File: rtl/relu_pool_fifo.sv
// relu_pool_fifo: 2-entry output FIFO with simultaneous push/pop support
module relu_pool_fifo import relu_pool_pkg::*; #(
  parameter int W = ZW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);
  logic [W-1:0] mem [2];
  logic wp, rp, pop_ok;
  logic [1:0] cnt;
  assign valid = cnt != 2'd0;
  assign full = cnt[1];
  assign dout = mem[rp];
  assign pop_ok = pop && valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= !wp;
      end
      if (pop_ok) rp <= !rp;
      cnt <= cnt + 2'(push) - 2'(pop_ok);
    end
  end
endmodule

// File: rtl/relu_pool_8_2.sv
// relu_pool_8_2: ReLU, max-pool over windows of P within vectors of L, saturate to ZW bits, 2-entry output FIFO
module relu_pool_8_2 import relu_pool_pkg::*; #(
  parameter int L = L_DEF,
  parameter int P = P_DEF,
  parameter int ZW = ZW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [Y_W-1:0] y_data,
  input  logic           y_valid,
  output logic           y_ready,
  output logic [ZW-1:0]  z_data,
  output logic           z_valid,
  input  logic           z_ready
);
  localparam int IW = L > 1 ? $clog2(L) : 1;
  localparam int PW = P > 1 ? $clog2(P) : 1;
  localparam int RW = Y_W - 1;
  localparam int EW = RW > ZW ? RW : ZW;
  logic [IW-1:0] idx;
  logic [PW-1:0] pos;
  logic [RW-1:0] m, r, mx;
  logic [EW-1:0] ext;
  logic [ZW-1:0] sat;
  logic acc, close, full;
  assign acc = y_valid && y_ready;
  assign r = y_data[Y_W-1] ? '0 : y_data[RW-1:0];
  assign mx = (pos == '0 || r > m) ? r : m;
  assign close = pos == PW'(P - 1) || idx == IW'(L - 1);
  assign ext = EW'(mx);
  assign sat = ext > EW'({ZW{1'b1}}) ? '1 : ext[ZW-1:0];
  assign y_ready = !full && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      pos <= '0;
      m <= '0;
    end else if (acc) begin
      idx <= idx == IW'(L - 1) ? '0 : idx + 1'b1;
      pos <= close ? '0 : pos + 1'b1;
      m <= mx;
    end
  end
  relu_pool_fifo #(.W(ZW)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(acc && close),
    .pop(z_valid && z_ready),
    .din(sat),
    .dout(z_data),
    .valid(z_valid),
    .full(full)
  );
endmodule

// File: tb/tb_relu_pool_8_2.sv
// tb_relu_pool_8_2: scoreboard bench for relu_pool_8_2 (default geometry and L=5,P=2)
module tb_relu_pool_8_2;
  logic clk = 1'b0, reset = 1'b1, y_valid = 1'b0, y_valid5 = 1'b0, z_ready = 1'b1;
  logic signed [22:0] y_data = '0;
  logic y_ready, z_valid, y_ready5, z_valid5;
  logic [15:0] z_data, z_data5;
  bit rand_z = 1'b0, model_on = 1'b0;
  int errors = 0, checks = 0, acc_cnt = 0, m_idx = 0;
  longint m_max = 0;
  int exp_q[$], exp5_q[$];

  always #5 clk = ~clk;

  relu_pool_8_2 dut (
    .clk(clk), .reset(reset), .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .z_data(z_data), .z_valid(z_valid), .z_ready(z_ready)
  );

  relu_pool_8_2 #(.L(5), .P(2), .ZW(16)) dut5 (
    .clk(clk), .reset(reset), .y_data(y_data), .y_valid(y_valid5), .y_ready(y_ready5),
    .z_data(z_data5), .z_valid(z_valid5), .z_ready(z_ready)
  );

  always @(negedge clk) begin : mon
    longint r, mx;
    int e;
    if (reset) m_idx = 0;
    else begin
      if (y_valid && y_ready) begin
        acc_cnt++;
        if (model_on) begin
          r = (longint'(y_data) < 0) ? 0 : longint'(y_data);
          mx = (m_idx % 2 == 0 || r > m_max) ? r : m_max;
          m_max = mx;
          if (m_idx % 2 == 1 || m_idx == 7) exp_q.push_back(int'(mx > 65535 ? 65535 : mx));
          m_idx = (m_idx == 7) ? 0 : m_idx + 1;
        end
      end
      if (z_valid && z_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL z_unexpected got=%0d expected=none", z_data);
        end else begin
          e = exp_q.pop_front();
          if (z_data !== 16'(e)) begin
            errors++;
            $display("FAIL z_data got=%0d expected=%0d", z_data, e);
          end
        end
      end
      if (z_valid5 && z_ready) begin
        checks++;
        if (exp5_q.size() == 0) begin
          errors++;
          $display("FAIL z5_unexpected got=%0d expected=none", z_data5);
        end else begin
          e = exp5_q.pop_front();
          if (z_data5 !== 16'(e)) begin
            errors++;
            $display("FAIL z5_data got=%0d expected=%0d", z_data5, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_z) z_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int v, input bit five);
    int n = 0;
    bit a = 1'b0;
    y_data = 23'(v);
    if (five) y_valid5 = 1'b1;
    else y_valid = 1'b1;
    do begin
      @(negedge clk);
      a = five ? y_ready5 : y_ready;
      step();
      n++;
    end while (!a && n < 200);
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=no_accept expected=accept value=%0d", v);
    end
    y_valid = 1'b0;
    y_valid5 = 1'b0;
    y_data = 'x;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks += 2;
    if (y_ready !== 1'b0) begin errors++; $display("FAIL reset_y_ready got=%b expected=0", y_ready); end
    if (z_valid !== 1'b0) begin errors++; $display("FAIL reset_z_valid got=%b expected=0", z_valid); end
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (y_ready !== 1'b1) begin errors++; $display("FAIL post_reset_y_ready got=%b expected=1", y_ready); end
    if (z_valid !== 1'b0) begin errors++; $display("FAIL post_reset_z_valid got=%b expected=0", z_valid); end
    step();
  endtask

  task automatic test_basic();
    int v[8] = '{3, -5, 7, 2, -1, -4, 100, 99};
    time t0;
    z_ready = 1'b1;
    exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(100);
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      send(v[i], 1'b0);
      if (i == 1) begin
        checks++;
        if (z_valid !== 1'b1 || z_data !== 16'd3) begin
          errors++;
          $display("FAIL latency got=valid%b/%0d expected=valid1/3", z_valid, z_data);
        end
      end
    end
    checks++;
    if ($time - t0 != 80) begin errors++; $display("FAIL throughput got=%0t expected=80", $time - t0); end
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int v[8] = '{70000, 5, -3, -9, 0, 0, 65535, 65536};
    int k = 0, n = 0;
    bit a;
    exp_q.push_back(65535); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(65535);
    z_ready = 1'b0;
    y_valid = 1'b1;
    y_data = 23'(v[0]);
    repeat (20) begin
      @(negedge clk);
      a = y_ready;
      step();
      if (a) begin k++; if (k < 8) y_data = 23'(v[k]); end
    end
    checks += 3;
    if (k != 4) begin errors++; $display("FAIL stall_accepts got=%0d expected=4", k); end
    if (y_ready !== 1'b0) begin errors++; $display("FAIL stall_y_ready got=%b expected=0", y_ready); end
    if (z_valid !== 1'b1 || z_data !== 16'd65535) begin
      errors++;
      $display("FAIL stall_hold got=valid%b/%0d expected=valid1/65535", z_valid, z_data);
    end
    z_ready = 1'b1;
    while (k < 8 && n < 200) begin
      @(negedge clk);
      a = y_ready;
      step();
      n++;
      if (a) begin k++; if (k < 8) y_data = 23'(v[k]); end
    end
    y_valid = 1'b0;
    y_data = 'x;
    idle(4);
    checks += 2;
    if (k != 8) begin errors++; $display("FAIL release_accepts got=%0d expected=8", k); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL release_drain got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int v[8] = '{3, -5, 7, 2, -1, -4, 100, 99};
    z_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(v[i], 1'b0);
    checks++;
    if (z_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_pending got=%b expected=1", z_valid); end
    reset = 1'b1;
    idle(2);
    checks++;
    if (z_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_flush got=%b expected=0", z_valid); end
    reset = 1'b0;
    z_ready = 1'b1;
    step();
    exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(100);
    for (int i = 0; i < 8; i++) send(v[i], 1'b0);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_drain got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_l5();
    int v[5] = '{1, 2, 3, 4, 9};
    z_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp5_q.push_back(2); exp5_q.push_back(4); exp5_q.push_back(9);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 5; i++) send(v[i], 1'b1);
    idle(4);
    checks++;
    if (exp5_q.size() != 0) begin errors++; $display("FAIL l5_drain got=%0d expected=0", exp5_q.size()); end
  endtask

  task automatic test_random();
    logic [22:0] b;
    int v, n = 0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    step();
    model_on = 1'b1;
    rand_z = 1'b1;
    for (int i = 0; i < 300 * 8; i++) begin
      idle($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 400) - 200;
        1: v = 65530 + $urandom_range(0, 10);
        default: begin b = 23'($urandom); v = int'($signed(b)); end
      endcase
      send(v, 1'b0);
    end
    model_on = 1'b0;
    rand_z = 1'b0;
    z_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin step(); n++; end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain got=%0d expected=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_l5();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
